// File: rtl/g711_coder_stream_if.sv
// Stream bundle for the G.711 coder: sample input side, code output side and saturation count.
interface g711_coder_stream_if #(
    parameter int DATA_IN_W = 15,
    parameter int TAG_W     = 4,
    parameter int SAT_CNT_W = 16
);
    logic signed [DATA_IN_W-1:0] data_in;
    logic [TAG_W-1:0]            tag_in;
    logic                        mode_in;
    logic                        valid_in;
    logic                        ready_in;
    logic [7:0]                  data_out;
    logic [TAG_W-1:0]            tag_out;
    logic                        valid_out;
    logic                        ready_out;
    logic                        sat_clr;
    logic [SAT_CNT_W-1:0]        sat_cnt;

    modport slave (
        input  data_in, tag_in, mode_in, valid_in, ready_out, sat_clr,
        output ready_in, data_out, tag_out, valid_out, sat_cnt
    );

    modport master (
        output data_in, tag_in, mode_in, valid_in, ready_out, sat_clr,
        input  ready_in, data_out, tag_out, valid_out, sat_cnt
    );
endinterface

// File: rtl/g711_coder_stream.sv
// Streaming G.711 A-law / mu-law encoder: 3-stage pipeline with a global stall enable,
// per-sample mode and tag, and a sticky saturation event counter.
module g711_coder_stream #(
    parameter int DATA_IN_W  = 15,
    parameter int DATA_OUT_W = 8,
    parameter int TAG_W      = 4,
    parameter int SAT_CNT_W  = 16
) (
    input logic                clk,
    input logic                rst,
    g711_coder_stream_if.slave bus
);
    localparam int                   MAG_W    = DATA_IN_W - 1;
    localparam int                   SH_A     = DATA_IN_W - 13;
    localparam int                   SH_MU    = DATA_IN_W - 14;
    localparam logic [12:0]          MU_CLIP  = 13'd8158;
    localparam logic [12:0]          MU_BIAS  = 13'd33;
    localparam logic [DATA_IN_W-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

    generate
        if (DATA_IN_W < 14 || DATA_IN_W > 24) begin : g_bad_data_in_w
            $error("g711_coder_stream: DATA_IN_W must be within 14..24");
        end
        if (DATA_OUT_W != 8) begin : g_bad_data_out_w
            $error("g711_coder_stream: DATA_OUT_W must be 8");
        end
    endgenerate

    // |x| with the most negative code pinned to the largest positive magnitude
    function automatic logic [MAG_W-1:0] f_abs_sat(input logic signed [DATA_IN_W-1:0] x);
        logic signed [DATA_IN_W-1:0] nx;
        if ($unsigned(x) == MOST_NEG) return {MAG_W{1'b1}};
        nx = -x;
        return x[DATA_IN_W-1] ? MAG_W'(nx) : MAG_W'(x);
    endfunction

    function automatic logic [SAT_CNT_W-1:0] f_sat_inc(input logic [SAT_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + SAT_CNT_W'(1);
    endfunction

    function automatic logic [6:0] f_alaw_seg(input logic [11:0] m);
        logic [6:0] r;
        r = {3'd0, m[4:1]};
        for (int p = 5; p <= 11; p++) begin
            if (m[p]) r = {3'(p - 4), 4'(m >> (p - 4))};
        end
        return r;
    endfunction

    // bias guarantees v >= 33, so bit 5 or above always holds the leading one
    function automatic logic [6:0] f_mulaw_seg(input logic [12:0] v);
        logic [6:0] r;
        r = 7'd0;
        for (int p = 5; p <= 12; p++) begin
            if (v[p]) r = {3'(p - 5), 4'(v >> (p - 4))};
        end
        return r;
    endfunction

    logic                 adv, accept;
    logic [MAG_W-1:0]     mag;
    logic [11:0]          m_a;
    logic [12:0]          m_mu;
    logic [12:0]          mag_s0;
    logic                 mu_over, sat_evt;

    logic                 vld_p0, vld_p1, vld_p2;
    logic                 sign_p0, mode_p0;
    logic [TAG_W-1:0]     tag_p0;
    logic [12:0]          mag_p0;
    logic                 sign_p1, mode_p1;
    logic [TAG_W-1:0]     tag_p1;
    logic [6:0]           segmant_p1;
    logic [DATA_OUT_W-1:0] code_p2;
    logic [TAG_W-1:0]     tag_p2;
    logic [SAT_CNT_W-1:0] sat_cnt_r;

    assign adv    = ~vld_p2 | bus.ready_out;
    assign accept = bus.valid_in & adv;

    always_comb begin
        mag     = f_abs_sat(bus.data_in);
        m_a     = 12'(mag >> SH_A);
        m_mu    = 13'(mag >> SH_MU);
        mu_over = (m_mu > MU_CLIP);
        if (bus.mode_in) mag_s0 = (mu_over ? MU_CLIP : m_mu) + MU_BIAS;
        else             mag_s0 = {1'b0, m_a};
        sat_evt = ($unsigned(bus.data_in) == MOST_NEG) | (bus.mode_in & mu_over);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= bus.valid_in;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            // stage 0: sign and scaled magnitude
            sign_p0    <= bus.data_in[DATA_IN_W-1];
            mode_p0    <= bus.mode_in;
            tag_p0     <= bus.tag_in;
            mag_p0     <= mag_s0;
            // stage 1: segment and mantissa
            sign_p1    <= sign_p0;
            mode_p1    <= mode_p0;
            tag_p1     <= tag_p0;
            segmant_p1 <= mode_p0 ? f_mulaw_seg(mag_p0) : f_alaw_seg(mag_p0[11:0]);
        end
    end

    // stage 2: code assembly; the output register is visible, so it is cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            code_p2 <= '0;
            tag_p2  <= '0;
        end else if (adv) begin
            code_p2 <= mode_p1 ? ~{sign_p1, segmant_p1} : ({~sign_p1, segmant_p1} ^ 8'h55);
            tag_p2  <= tag_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   sat_cnt_r <= '0;
        else if (bus.sat_clr)      sat_cnt_r <= '0;
        else if (accept & sat_evt) sat_cnt_r <= f_sat_inc(sat_cnt_r);
    end

    assign bus.ready_in  = adv;
    assign bus.valid_out = vld_p2;
    assign bus.data_out  = code_p2;
    assign bus.tag_out   = tag_p2;
    assign bus.sat_cnt   = sat_cnt_r;
endmodule

// File: tb/tb_g711_coder_stream.sv
// Directed bench for g711_coder_stream: vector table, streaming, backpressure,
// mode alternation, sticky saturation counter and mid-stream reset.
module tb_g711_coder_stream;
    localparam int DATA_IN_W = 15;
    localparam int TAG_W     = 4;
    localparam int SAT_CNT_W = 2;
    localparam int MOST_NEG  = -(1 << (DATA_IN_W - 1));
    localparam int MAX_POS   = (1 << (DATA_IN_W - 1)) - 1;

    logic tb_clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    g711_coder_stream_if #(.DATA_IN_W(DATA_IN_W), .TAG_W(TAG_W), .SAT_CNT_W(SAT_CNT_W)) bus ();

    g711_coder_stream #(
        .DATA_IN_W (DATA_IN_W),
        .DATA_OUT_W(8),
        .TAG_W     (TAG_W),
        .SAT_CNT_W (SAT_CNT_W)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .bus(bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int   din;
        bit   mode;
        int   code;
        int   sat;
    } vec_t;

    vec_t tbl [22];

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural G.711 reference written from the companding definition
    function automatic int model_code(input int x, input bit mu);
        int s, mag, m, v, p, seg, mant;
        s   = (x < 0) ? 1 : 0;
        mag = (x < 0) ? -x : x;
        if (mag > MAX_POS) mag = MAX_POS;
        if (!mu) begin
            m = mag >> (DATA_IN_W - 13);
            if (m < 32) begin
                seg  = 0;
                mant = (m >> 1) & 15;
            end else begin
                p = 5;
                while ((m >> (p + 1)) != 0) p++;
                seg  = p - 4;
                mant = (m >> (p - 4)) & 15;
            end
            return (((s == 1) ? 0 : 128) | (seg << 4) | mant) ^ 'h55;
        end
        m = mag >> (DATA_IN_W - 14);
        if (m > 8158) m = 8158;
        v = m + 33;
        p = 5;
        while ((v >> (p + 1)) != 0) p++;
        seg  = p - 5;
        mant = (v >> (p - 4)) & 15;
        return 255 - ((s << 7) | (seg << 4) | mant);
    endfunction

    function automatic int stream_val(input int k);
        return ((k * 131) % 32768) - 16384;
    endfunction

    function automatic int bp_val(input int k);
        return ((k * 977 + 301) % 32768) - 16384;
    endfunction

    task automatic send_one(input int idx, input vec_t v);
        int waited;
        string nm;
        nm = $sformatf("vec%0d", idx);
        bus.sat_clr = 1'b1;
        tick();
        bus.sat_clr  = 1'b0;
        bus.data_in  = DATA_IN_W'(v.din);
        bus.mode_in  = v.mode;
        bus.tag_in   = TAG_W'(idx);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        check({nm, " sat_cnt"}, 32'(bus.sat_cnt), 32'(v.sat));
        waited = 1;
        while (!bus.valid_out && waited < 8) begin
            tick();
            waited++;
        end
        check({nm, " latency"}, 32'(waited), 32'd3);
        check({nm, " code"}, 32'(bus.data_out), 32'(v.code));
        check({nm, " tag"}, 32'(bus.tag_out), 32'(idx % 16));
        tick();
    endtask

    task automatic run_stream(input int n, input bit alt);
        int first_v, last_v, nvalid, exp;
        first_v = -1;
        last_v  = -1;
        nvalid  = 0;
        bus.ready_out = 1'b1;
        for (int k = 0; k < n + 6; k++) begin
            if (k < n) begin
                bus.data_in  = DATA_IN_W'(alt ? 1000 : stream_val(k));
                bus.mode_in  = alt ? k[0] : (k % 3 == 0);
                bus.tag_in   = TAG_W'(k);
                bus.valid_in = 1'b1;
            end else begin
                bus.valid_in = 1'b0;
            end
            tick();
            if (bus.valid_out) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                if (alt) exp = nvalid[0] ? 'hBF : 'hEA;
                else     exp = model_code(stream_val(nvalid), nvalid % 3 == 0);
                check(alt ? "alt code" : "stream code", 32'(bus.data_out), 32'(exp));
                check(alt ? "alt tag" : "stream tag", 32'(bus.tag_out), 32'(nvalid % 16));
                nvalid++;
            end
        end
        check("stream first valid edge", 32'(first_v), 32'd2);
        check("stream valid count", 32'(nvalid), 32'(n));
        check("stream valid contiguous", 32'(last_v - first_v + 1), 32'(n));
    endtask

    task automatic run_backpressure(input int n);
        int sent, got;
        logic stall;
        logic [7:0] hold_d;
        logic [TAG_W-1:0] hold_t;
        sent  = 0;
        got   = 0;
        stall = 1'b0;
        hold_d = '0;
        hold_t = '0;
        for (int cyc = 0; cyc < 2000 && got < n; cyc++) begin
            bus.ready_out = ($urandom_range(0, 1) == 1);
            bus.data_in   = DATA_IN_W'(bp_val(sent));
            bus.mode_in   = (sent % 4 == 1) || (sent % 4 == 2);
            bus.tag_in    = TAG_W'(sent);
            bus.valid_in  = (sent < n);
            #1;
            if (stall) begin
                check("bp stall valid", 32'(bus.valid_out), 32'd1);
                check("bp stall data", 32'(bus.data_out), 32'(hold_d));
                check("bp stall tag", 32'(bus.tag_out), 32'(hold_t));
            end
            if (bus.valid_out && bus.ready_out) begin
                check("bp code", 32'(bus.data_out),
                      32'(model_code(bp_val(got), (got % 4 == 1) || (got % 4 == 2))));
                check("bp tag", 32'(bus.tag_out), 32'(got % 16));
                got++;
            end
            stall  = bus.valid_out & ~bus.ready_out;
            hold_d = bus.data_out;
            hold_t = bus.tag_out;
            if (bus.valid_in && bus.ready_in) sent++;
            tick();
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        check("bp delivered", 32'(got), 32'(n));
        check("bp accepted", 32'(sent), 32'(n));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp no duplicate", 32'(bus.valid_out), 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = '{0,       1'b0, 'hD5, 0};
        tbl[1]  = '{8,       1'b0, 'hD4, 0};
        tbl[2]  = '{16383,   1'b0, 'hAA, 0};
        tbl[3]  = '{-16384,  1'b0, 'h2A, 1};
        tbl[4]  = '{1000,    1'b0, 'hEA, 0};
        tbl[5]  = '{-1000,   1'b0, 'h6A, 0};
        tbl[6]  = '{-1,      1'b0, 'h55, 0};
        tbl[7]  = '{100,     1'b0, 'hD9, 0};
        tbl[8]  = '{-16383,  1'b0, 'h2A, 0};
        tbl[9]  = '{127,     1'b0, 'hDA, 0};
        tbl[10] = '{128,     1'b0, 'hC5, 0};
        tbl[11] = '{0,       1'b1, 'hFF, 0};
        tbl[12] = '{16383,   1'b1, 'h80, 1};
        tbl[13] = '{-16384,  1'b1, 'h00, 1};
        tbl[14] = '{1000,    1'b1, 'hBF, 0};
        tbl[15] = '{-1000,   1'b1, 'h3F, 0};
        tbl[16] = '{8,       1'b1, 'hFD, 0};
        tbl[17] = '{-1,      1'b1, 'h7F, 0};
        tbl[18] = '{100,     1'b1, 'hEB, 0};
        tbl[19] = '{-16383,  1'b1, 'h00, 1};
        tbl[20] = '{16316,   1'b1, 'h80, 0};
        tbl[21] = '{16318,   1'b1, 'h80, 1};

        rst           = 1'b1;
        bus.data_in   = '0;
        bus.tag_in    = '0;
        bus.mode_in   = 1'b0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        bus.sat_clr   = 1'b0;
        tick();
        tick();
        check("reset valid_out", 32'(bus.valid_out), 32'd0);
        check("reset data_out", 32'(bus.data_out), 32'd0);
        check("reset tag_out", 32'(bus.tag_out), 32'd0);
        check("reset sat_cnt", 32'(bus.sat_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("post-reset ready_in", 32'(bus.ready_in), 32'd1);

        for (int i = 0; i < 22; i++) send_one(i, tbl[i]);

        run_stream(256, 1'b0);
        run_stream(8, 1'b1);
        run_backpressure(60);

        // sticky counter: five saturating accepts on a 2-bit counter
        bus.ready_out = 1'b1;
        bus.sat_clr   = 1'b1;
        tick();
        bus.sat_clr   = 1'b0;
        bus.data_in   = DATA_IN_W'(MOST_NEG);
        bus.valid_in  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.mode_in = i[0];
            tick();
            check("sat_cnt sticky", 32'(bus.sat_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
        end
        bus.sat_clr = 1'b1;
        tick();
        check("sat_clr over accept", 32'(bus.sat_cnt), 32'd0);
        bus.sat_clr = 1'b0;
        tick();
        check("sat after clear", 32'(bus.sat_cnt), 32'd1);
        bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // reset with the pipe full
        bus.data_in  = DATA_IN_W'(MOST_NEG);
        bus.mode_in  = 1'b0;
        bus.valid_in = 1'b1;
        tick();
        tick();
        tick();
        check("pre-reset valid_out", 32'(bus.valid_out), 32'd1);
        check("pre-reset sat_cnt", 32'(bus.sat_cnt), 32'd3);
        bus.valid_in = 1'b0;
        rst = 1'b1;
        tick();
        check("mid rst valid_out", 32'(bus.valid_out), 32'd0);
        check("mid rst data_out", 32'(bus.data_out), 32'd0);
        check("mid rst sat_cnt", 32'(bus.sat_cnt), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no stale output", 32'(bus.valid_out), 32'd0);
        end
        check("ready after rst", 32'(bus.ready_in), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
